// File: rtl/aexm_pkg.sv
// Shared types and constants for the aexm instruction fetch stage.
package aexm_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    // Decoder-side filler word presented while no fetched instruction is available.
    localparam word_t AEXM_NOP_OP   = 32'h8800_0000;
    localparam addr_t AEXM_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic addr_t word_align(input addr_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/aexm_ifetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs between the icache and the decoder.
// Flush has priority over push and pop; pop on empty and push on full are ignored.
module aexm_ifetch_fifo
    import aexm_pkg::*;
#(
    parameter int FDEPTH = 4,
    localparam int PW = $clog2(FDEPTH),
    localparam int CW = $clog2(FDEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  addr_t         i_push_pc,
    input  word_t         i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output addr_t         o_head_pc,
    output word_t         o_head_dat,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    addr_t         r_pc_mem  [FDEPTH];
    word_t         r_dat_mem [FDEPTH];

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(FDEPTH)) || w_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at FDEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) begin
            r_pc_mem[r_wr_ptr]  <= i_push_pc;
            r_dat_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_pc  = r_pc_mem[r_rd_ptr];
    assign o_head_dat = r_dat_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/aexm_ifetch.sv
// Instruction fetch stage: fetch PC generation, single-outstanding icache
// handshake, prefetch FIFO and branch redirect handling.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no request on the bus; issue at fpc (or branch target) next
//   ST_REQ  | request pending at ic_adr; ack is pushed into the FIFO
//   ST_DROP | request pending but redirected; ack is discarded
module aexm_ifetch
    import aexm_pkg::*;
#(
    parameter int    FDEPTH   = 4,
    parameter addr_t RESET_PC = AEXM_RESET_PC,
    parameter word_t NOP_OP   = AEXM_NOP_OP
) (
    input  logic        gclk,
    input  logic        grst,
    output logic [31:0] ic_adr,
    output logic        ic_req,
    input  logic        ic_ack,
    input  logic [31:0] ic_dat,
    output logic [31:0] if_dat,
    output logic [31:0] if_pc,
    output logic        if_vld,
    output logic        if_stall,
    input  logic        if_take,
    input  logic        br_take,
    input  logic [31:0] br_tgt
);

    localparam int CW = $clog2(FDEPTH) + 1;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    addr_t        r_fpc;
    addr_t        w_fpc_nxt;
    addr_t        r_adr;
    addr_t        w_adr_nxt;
    addr_t        w_tgt;
    logic         w_push;

    addr_t         w_head_pc;
    word_t         w_head_dat;
    logic [CW-1:0] w_count;
    logic          w_empty;

    assign w_tgt = word_align(br_tgt);

    // Next-state, next fetch PC and bus address selection.
    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_adr_nxt   = r_adr;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // No request is pending here, so count alone bounds the FIFO.
                if (br_take) begin
                    w_fpc_nxt   = w_tgt;
                    w_adr_nxt   = w_tgt;
                    w_state_nxt = ST_REQ;
                end else if (w_count < CW'(FDEPTH)) begin
                    w_adr_nxt   = r_fpc;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ic_ack) begin
                    w_state_nxt = ST_IDLE;
                    if (br_take) begin
                        w_fpc_nxt = w_tgt;
                    end else begin
                        w_push    = 1'b1;
                        w_fpc_nxt = r_fpc + 32'd4;
                    end
                end else if (br_take) begin
                    // Bus must stay stable, so the old request runs to completion in DROP.
                    w_fpc_nxt   = w_tgt;
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (br_take) begin
                    w_fpc_nxt = w_tgt;
                end
                if (ic_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, fetch PC and bus address registers.
    always_ff @(posedge gclk) begin
        if (grst) begin
            r_state <= ST_IDLE;
            r_fpc   <= RESET_PC;
            r_adr   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;
            r_adr   <= w_adr_nxt;
        end
    end

    // Pushed PC is r_fpc, which equals r_adr whenever the request was not redirected.
    aexm_ifetch_fifo #(
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .clk        (gclk),
        .rst        (grst),
        .i_push     (w_push),
        .i_push_pc  (r_fpc),
        .i_push_dat (ic_dat),
        .i_pop      (if_take),
        .i_flush    (br_take),
        .o_head_pc  (w_head_pc),
        .o_head_dat (w_head_dat),
        .o_count    (w_count),
        .o_empty    (w_empty)
    );

    assign ic_req   = (r_state != ST_IDLE);
    assign ic_adr   = r_adr;
    assign if_vld   = !w_empty;
    assign if_stall = w_empty;
    assign if_dat   = w_empty ? NOP_OP : w_head_dat;
    assign if_pc    = w_empty ? 32'd0 : w_head_pc;

endmodule

// File: tb/tb_aexm_ifetch.sv
// Randomised scoreboard bench for aexm_ifetch.
module tb_aexm_ifetch;

    localparam int          FDEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h8800_0000;

    logic        gclk = 1'b0;
    logic        grst;
    logic [31:0] ic_adr;
    logic        ic_req;
    logic        ic_ack;
    logic [31:0] ic_dat;
    logic [31:0] if_dat;
    logic [31:0] if_pc;
    logic        if_vld;
    logic        if_stall;
    logic        if_take;
    logic        br_take;
    logic [31:0] br_tgt;

    always #5 gclk = ~gclk;

    aexm_ifetch #(
        .FDEPTH   (FDEPTH),
        .RESET_PC (RST_PC),
        .NOP_OP   (NOP)
    ) dut (
        .gclk     (gclk),
        .grst     (grst),
        .ic_adr   (ic_adr),
        .ic_req   (ic_req),
        .ic_ack   (ic_ack),
        .ic_dat   (ic_dat),
        .if_dat   (if_dat),
        .if_pc    (if_pc),
        .if_vld   (if_vld),
        .if_stall (if_stall),
        .if_take  (if_take),
        .br_take  (br_take),
        .br_tgt   (br_tgt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } ent_t;

    int   checks   = 0;
    int   errors   = 0;
    int   consumed = 0;
    ent_t exp_q[$];

    // Reference model: next program address the fetch stream should deliver.
    logic [31:0] m_fpc   = RST_PC;
    logic        m_stale = 1'b0;
    logic        c_req;

    // Monitor history.
    logic        pend     = 1'b0;
    logic [31:0] padr     = '0;
    int          exp_req  = 0;
    logic        prev_rst = 1'b0;
    int          occ;
    ent_t        e_mon;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return pc + 32'd1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; the model absorbs the cycle's events after the edge.
    task automatic step(input logic ack, input logic take, input logic br,
                        input logic [31:0] tgt, input logic rst, input logic stray);
        c_req   = (ic_req === 1'b1);
        ic_ack  = stray || (ack && c_req);
        ic_dat  = ic_ack ? (stray ? 32'hDEAD_BEEF : mem_word(ic_adr)) : $urandom();
        if_take = take;
        br_take = br;
        br_tgt  = tgt;
        grst    = rst;
        @(posedge gclk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_fpc   = RST_PC;
            m_stale = 1'b0;
        end else begin
            if (c_req && ic_ack && !m_stale && !br) begin
                exp_q.push_back(ent_t'{pc: m_fpc, dat: mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
            if (br) begin
                exp_q.delete();
                m_fpc = {tgt[31:2], 2'b00};
            end
            if (c_req && !ic_ack && br) m_stale = 1'b1;
            else if (c_req && ic_ack)   m_stale = 1'b0;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (ic_req !== 1'b1 && n < 50) begin
            step(0, 1, 0, 0, 0, 0);
            n++;
        end
        chk("wait_req_timeout", {31'd0, ic_req}, 32'd1);
    endtask

    // Monitor: bus protocol, output consistency and in-order delivery of expected words.
    initial begin
        forever begin
            @(negedge gclk);
            occ = exp_q.size();
            if (prev_rst) begin
                chk("rst_req", {31'd0, ic_req}, 32'd0);
                chk("rst_vld", {31'd0, if_vld}, 32'd0);
                chk("rst_dat", if_dat, NOP);
                chk("rst_pc", if_pc, 32'd0);
                chk("rst_adr", ic_adr, RST_PC);
            end
            if (pend) begin
                chk("hold_req", {31'd0, ic_req}, 32'd1);
                chk("hold_adr", ic_adr, padr);
            end else if (ic_req === 1'b1) begin
                chk("req_adr", ic_adr, m_fpc);
            end
            if (exp_req == 1)      chk("issue", {31'd0, ic_req}, 32'd1);
            else if (exp_req == 2) chk("no_issue", {31'd0, ic_req}, 32'd0);
            chk("stall", {31'd0, if_stall}, {31'd0, !if_vld});
            chk("adr_align", {30'd0, ic_adr[1:0]}, 32'd0);
            chk("vld", {31'd0, if_vld}, {31'd0, (occ > 0)});
            if (if_vld !== 1'b1) chk("nop", if_dat, NOP);
            if (if_take && if_vld && !br_take && !grst) begin
                if (occ == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL underflow: got word pc %h expected none", if_pc);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("seq_pc", if_pc, e_mon.pc);
                    chk("seq_dat", if_dat, e_mon.dat);
                    consumed++;
                end
            end
            pend    = (ic_req === 1'b1) && !ic_ack && !grst;
            padr    = ic_adr;
            exp_req = 0;
            if (!grst && ic_req === 1'b0) exp_req = (br_take || occ < FDEPTH) ? 1 : 2;
            prev_rst = grst;
        end
    end

    initial begin
        int pa, pt, pb;
        logic [31:0] t;
        grst = 1'b1; ic_ack = 1'b0; ic_dat = '0;
        if_take = 1'b0; br_take = 1'b0; br_tgt = '0;

        repeat (3) step(0, 0, 0, 0, 1, 0);

        // Streaming with zero-wait acks and continuous consumption.
        repeat (20) step(1, 1, 0, 0, 0, 0);

        // Fill without consumption: fetch must stop at FDEPTH words.
        repeat (20) step(1, 0, 0, 0, 0, 0);
        chk("full_no_req", {31'd0, ic_req}, 32'd0);
        chk("full_vld", {31'd0, if_vld}, 32'd1);
        step(0, 1, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        repeat (12) step(1, 1, 0, 0, 0, 0);

        // Redirect while a request is unacknowledged.
        wait_req();
        step(0, 1, 1, 32'h0000_0203, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        repeat (15) step(1, 1, 0, 0, 0, 0);

        // Redirect coinciding with an ack.
        wait_req();
        step(1, 1, 1, 32'h0000_0400, 0, 0);
        chk("flush_vld", {31'd0, if_vld}, 32'd0);
        chk("flush_nop", if_dat, NOP);
        repeat (10) step(1, 1, 0, 0, 0, 0);

        // Partial fill then simultaneous push/pop, then take while empty.
        repeat (6) step(1, 0, 0, 0, 0, 0);
        repeat (10) step(1, 1, 0, 0, 0, 0);
        repeat (8) step(0, 1, 0, 0, 0, 0);

        // Reset during an outstanding request, then a stray ack.
        repeat (4) step(1, 1, 0, 0, 0, 0);
        wait_req();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("stray_vld", {31'd0, if_vld}, 32'd0);
        repeat (10) step(1, 1, 0, 0, 0, 0);

        // Fetch PC wraps past the top of the address space.
        step(1, 1, 1, 32'hFFFF_FFF9, 0, 0);
        repeat (20) step(1, 1, 0, 0, 0, 0);

        // Randomised traffic with changing ack/take/branch rates.
        pa = 80; pt = 80; pb = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pa = $urandom_range(30, 100);
                pt = $urandom_range(20, 100);
                pb = $urandom_range(0, 8);
            end
            t = $urandom();
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            step($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pt,
                 $urandom_range(0, 99) < pb, t, $urandom_range(0, 299) == 0, 0);
        end

        chk("progress", {31'd0, (consumed > 100)}, 32'd1);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
